// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - writeback scheduler: busy scoreboard, long-unit result FIFO, pipe-priority write port.
// Optional macro REGFILE_SB_FWD_EN: the FIFO head being written this cycle does not count as busy for stall_o.
module regfile_wb_sched #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  output logic        issue_ready_o,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  id_rd_i,
  output logic        stall_o,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_rd_i,
  input  logic [31:0] pipe_data_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_rd_i,
  input  logic [31:0] lu_data_i,
  output logic        lu_ready_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic        err_o
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  logic [31:0]   busy;
  logic [31:0]   busy_eff;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;
  logic [4:0]    q_rd   [LQ_DEPTH];
  logic [31:0]   q_data [LQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          pipe_act;
  logic          issue_fire;
  logic          err_set;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign head_rd   = q_rd[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(LQ_DEPTH));
  assign pipe_act  = pipe_we_i && (pipe_rd_i != 5'd0);

  // The main pipeline owns the write port; the FIFO head only drains on idle cycles.
  assign pop        = !rst_i && !pipe_act && !empty;
  assign lu_ready_o = !rst_i && !full;
  assign push       = lu_valid_i && lu_ready_o;

  assign issue_ready_o = !rst_i && !busy[issue_rd_i];
  assign issue_fire    = issue_valid_i && issue_ready_o;

  assign set_mask = (issue_fire && issue_rd_i != 5'd0) ? (32'd1 << issue_rd_i) : 32'd0;
  assign clr_mask = pop ? (32'd1 << head_rd) : 32'd0;

`ifdef REGFILE_SB_FWD_EN
  assign busy_eff = busy & ~clr_mask;
`else
  assign busy_eff = busy;
`endif

  assign stall_o = !rst_i && ((RSaddr_i != 5'd0 && busy_eff[RSaddr_i]) ||
                              (RTaddr_i != 5'd0 && busy_eff[RTaddr_i]) ||
                              (id_rd_i  != 5'd0 && busy_eff[id_rd_i]));

  assign err_set = (push && lu_rd_i != 5'd0 && !busy[lu_rd_i]) ||
                   (pipe_act && busy[pipe_rd_i]);

  always_comb begin
    RegWrite_o = 1'b0;
    RDaddr_o   = 5'd0;
    RDdata_o   = 32'd0;
    if (!rst_i && pipe_act) begin
      RegWrite_o = 1'b1;
      RDaddr_o   = pipe_rd_i;
      RDdata_o   = pipe_data_i;
    end else if (pop) begin
      RegWrite_o = (head_rd != 5'd0);
      RDaddr_o   = head_rd;
      RDdata_o   = head_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_rd[wr_ptr]   <= lu_rd_i;
      q_data[wr_ptr] <= lu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy   <= 32'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A fresh issue wins over a clear of the same rd.
      busy  <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
      err_o <= err_o | err_set;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - bench for regfile_wb_sched: directed scenarios plus random traffic against a queue model.
module tb_regfile_wb_sched;
  localparam int LQ = 2;
`ifdef REGFILE_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs_addr, rt_addr, id_rd;
  logic        stall;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        err;

  regfile_wb_sched #(.LQ_DEPTH(LQ)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .RSaddr_i(rs_addr), .RTaddr_i(rt_addr), .id_rd_i(id_rd), .stall_o(stall),
    .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .lu_valid_i(lu_valid), .lu_rd_i(lu_rd), .lu_data_i(lu_data), .lu_ready_o(lu_ready),
    .RegWrite_o(reg_write), .RDaddr_o(rd_addr), .RDdata_o(rd_data), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   mbusy[32];
  bit   merr  = 1'b0;
  bit   armed = 1'b0;

  // Model: outputs follow from the queue and busy set; state advances once per cycle with the inputs seen here.
  always @(negedge clk) begin : compare
    bit          pact, popping, e_wr, e_ir, e_lr, e_st, acc;
    logic [4:0]  e_addr, a;
    logic [31:0] e_data;
    ent_t        h;
    pact    = pipe_we && (pipe_rd != 5'd0);
    popping = !rst && !pact && (mq.size() > 0);
    h.rd = 5'd0; h.data = 32'd0;
    if (mq.size() > 0) h = mq[0];
    e_wr = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    if (!rst && pact) begin
      e_wr = 1'b1; e_addr = pipe_rd; e_data = pipe_data;
    end else if (popping) begin
      e_wr = (h.rd != 5'd0); e_addr = h.rd; e_data = h.data;
    end
    e_ir = !rst && !mbusy[issue_rd];
    e_lr = !rst && (mq.size() < LQ);
    e_st = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? rs_addr : (k == 1) ? rt_addr : id_rd;
      if (!rst && a != 5'd0 && mbusy[a] && !(FWD && popping && h.rd == a)) e_st = 1'b1;
    end
    if (armed) begin
      chk("regwrite", {31'd0, reg_write}, {31'd0, e_wr});
      if (e_wr || rst) begin
        chk("rdaddr", {27'd0, rd_addr}, {27'd0, e_addr});
        chk("rddata", rd_data, e_data);
      end
      chk("issue_ready", {31'd0, issue_ready}, {31'd0, e_ir});
      chk("lu_ready", {31'd0, lu_ready}, {31'd0, e_lr});
      chk("stall", {31'd0, stall}, {31'd0, e_st});
      chk("err", {31'd0, err}, {31'd0, merr});
    end
    if (rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      merr = 1'b0;
    end else begin
      acc = lu_valid && e_lr;
      if ((acc && lu_rd != 5'd0 && !mbusy[lu_rd]) || (pact && mbusy[pipe_rd])) merr = 1'b1;
      if (popping) begin
        mbusy[h.rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back('{rd: lu_rd, data: lu_data});
      if (issue_valid && e_ir && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic quiet();
    issue_valid = 1'b0; issue_rd = 5'd0;
    rs_addr = 5'd0; rt_addr = 5'd0; id_rd = 5'd0;
    pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    next(); next();
    armed = 1'b1;
    rst = 1'b0;

    // Issue rd 5 and hold a reader of r5 until the long result lands.
    issue_valid = 1'b1; issue_rd = 5'd5; rs_addr = 5'd5;
    neg(); chk("s28_issue_ready", {31'd0, issue_ready}, 32'd1); chk("s28_no_stall_yet", {31'd0, stall}, 32'd0);
    next(); issue_valid = 1'b0;
    neg(); chk("s28_stall", {31'd0, stall}, 32'd1);
    next();
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF;
    neg(); chk("s28_lu_ready", {31'd0, lu_ready}, 32'd1); chk("s28_stall_hold", {31'd0, stall}, 32'd1);
    next(); lu_valid = 1'b0;
    neg();
    chk("s28_we", {31'd0, reg_write}, 32'd1);
    chk("s28_addr", {27'd0, rd_addr}, 32'd5);
    chk("s28_data", rd_data, 32'hDEADBEEF);
    chk("s28_stall_write_cycle", {31'd0, stall}, FWD ? 32'd0 : 32'd1);
    next();
    neg(); chk("s28_stall_released", {31'd0, stall}, 32'd0);
    rs_addr = 5'd0;

    // Pipe write of r3 pre-empts a queued r7.
    next(); issue_valid = 1'b1; issue_rd = 5'd7;
    next(); issue_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h77;
    next(); lu_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    neg(); chk("s29_first_addr", {27'd0, rd_addr}, 32'd3); chk("s29_first_data", rd_data, 32'h33);
    next(); pipe_we = 1'b0;
    neg(); chk("s29_second_addr", {27'd0, rd_addr}, 32'd7); chk("s29_second_data", rd_data, 32'h77);
    next();
    neg(); chk("s29_idle", {31'd0, reg_write}, 32'd0);

    // Three back-to-back results while the pipe holds the port: third must wait.
    for (int r = 10; r <= 12; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      next();
    end
    issue_valid = 1'b0;
    pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h11;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'hA0;
    neg(); chk("s30_acc0", {31'd0, lu_ready}, 32'd1);
    next(); lu_rd = 5'd11; lu_data = 32'hB0;
    neg(); chk("s30_acc1", {31'd0, lu_ready}, 32'd1);
    next(); lu_rd = 5'd12; lu_data = 32'hC0;
    neg(); chk("s30_full", {31'd0, lu_ready}, 32'd0); chk("s30_pipe_addr", {27'd0, rd_addr}, 32'd1);
    next(); pipe_we = 1'b0;
    neg(); chk("s30_drain0", {27'd0, rd_addr}, 32'd10); chk("s30_full_pop", {31'd0, lu_ready}, 32'd0);
    next();
    neg(); chk("s30_drain1", {27'd0, rd_addr}, 32'd11); chk("s30_acc2", {31'd0, lu_ready}, 32'd1);
    next(); lu_valid = 1'b0;
    neg(); chk("s30_drain2", {27'd0, rd_addr}, 32'd12); chk("s30_data2", rd_data, 32'hC0);
    next();
    neg(); chk("s30_no_err", {31'd0, err}, 32'd0);

    // Result for a never-issued r9: flagged, still written.
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    next(); lu_valid = 1'b0;
    neg(); chk("s31_write", {27'd0, rd_addr}, 32'd9); chk("s31_we", {31'd0, reg_write}, 32'd1); chk("s31_err", {31'd0, err}, 32'd1);
    next(); next();
    neg(); chk("s31_err_sticky", {31'd0, err}, 32'd1);

    // Re-issue of r4 in the cycle its result is written is refused, accepted next cycle.
    next(); issue_valid = 1'b1; issue_rd = 5'd4;
    next(); issue_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
    next(); lu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd4;
    neg(); chk("s32_write4", {27'd0, rd_addr}, 32'd4); chk("s32_refused", {31'd0, issue_ready}, 32'd0);
    next();
    neg(); chk("s32_accepted", {31'd0, issue_ready}, 32'd1);
    next(); issue_valid = 1'b0;

    // Reset with two results queued.
    issue_valid = 1'b1; issue_rd = 5'd13;
    next(); issue_rd = 5'd14;
    next(); issue_valid = 1'b0; pipe_we = 1'b1; pipe_rd = 5'd2; lu_valid = 1'b1; lu_rd = 5'd13;
    next(); lu_rd = 5'd14;
    next(); lu_valid = 1'b0;
    neg(); chk("s33_queued_full", {31'd0, lu_ready}, 32'd0);
    next(); rst = 1'b1; pipe_we = 1'b0; rs_addr = 5'd13; issue_rd = 5'd13;
    neg();
    chk("s33_rst_we", {31'd0, reg_write}, 32'd0);
    chk("s33_rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("s33_rst_issue_ready", {31'd0, issue_ready}, 32'd0);
    chk("s33_rst_stall", {31'd0, stall}, 32'd0);
    next(); rst = 1'b0;
    neg();
    chk("s33_post_we", {31'd0, reg_write}, 32'd0);
    chk("s33_post_stall", {31'd0, stall}, 32'd0);
    chk("s33_post_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("s33_post_err", {31'd0, err}, 32'd0);
    next();
    neg(); chk("s33_post_we2", {31'd0, reg_write}, 32'd0);
    quiet();
    next();

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 7));
      rs_addr     = 5'($urandom_range(0, 7));
      rt_addr     = 5'($urandom_range(0, 7));
      id_rd       = 5'($urandom_range(0, 7));
      pipe_we     = ($urandom_range(0, 3) == 0);
      pipe_rd     = 5'($urandom_range(0, 15));
      pipe_data   = $urandom;
      lu_valid    = ($urandom_range(0, 1) == 0);
      lu_rd       = 5'($urandom_range(0, 7));
      lu_data     = $urandom;
      next();
    end
    rst = 1'b0;
    quiet();
    repeat (4) next();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
